video_timing_gen: RTL and testbench

//  Parametrised successor to the fixed 640x480 sync generator. Produces HS/VS/blank_n and

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/video_timing_gen_if.sv | 33 +++
 rtl/video_axis_counter.sv | 38 +++
 rtl/video_timing_gen.sv | 168 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared types, mode constants and helpers for the parametrised video timing generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vtg_state_t;

  typedef struct packed {
    int sync;
    int back;
    int active;
    int front;
    int pol;
  } axis_mode_t;

  localparam axis_mode_t VGA_640x480_60_H  = '{sync: 96,  back: 48, active: 640, front: 16, pol: 0};
  localparam axis_mode_t VGA_640x480_60_V  = '{sync: 2,   back: 33, active: 480, front: 10, pol: 0};
  localparam axis_mode_t SVGA_800x600_60_H = '{sync: 128, back: 88, active: 800, front: 40, pol: 1};
  localparam axis_mode_t SVGA_800x600_60_V = '{sync: 4,   back: 23, active: 600, front: 1,  pol: 1};

  function automatic int tot(input int sync, input int back, input int act, input int front);
    return sync + back + act + front;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle between the timing generator and the frame-buffer reader / DAC path.
interface video_timing_gen_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 9
);
  import video_timing_pkg::*;

  // pix_ce qualifies every advance of the generator; run is a level request that is
  // sampled on every clock, and running reports whether frames are being produced.
  logic             pix_ce;
  logic             run;
  logic             running;
  logic             HS;
  logic             VS;
  logic             blank_n;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             line_start;
  logic             frame_start;
  logic             vblank_start;
  vtg_state_t       state;

  modport master (
    input  pix_ce, run,
    output running, HS, VS, blank_n, col, row, line_start, frame_start, vblank_start, state
  );

  modport slave (
    output pix_ce, run,
    input  running, HS, VS, blank_n, col, row, line_start, frame_start, vblank_start, state
  );

endinterface

// File: rtl/video_axis_counter.sv
// Wrapping position counter for one timing axis; tc_o flags the last position.
module video_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Mode-parametrised sync/blank/position generator with run/drain control that stops on a
// frame boundary. All state changes on the falling edge of vga_clk to give the DAC setup margin.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_SYNC   = VGA_640x480_60_H.sync,
  parameter int H_BACK   = VGA_640x480_60_H.back,
  parameter int H_ACTIVE = VGA_640x480_60_H.active,
  parameter int H_FRONT  = VGA_640x480_60_H.front,
  parameter int V_SYNC   = VGA_640x480_60_V.sync,
  parameter int V_BACK   = VGA_640x480_60_V.back,
  parameter int V_ACTIVE = VGA_640x480_60_V.active,
  parameter int V_FRONT  = VGA_640x480_60_V.front,
  parameter int H_POL    = VGA_640x480_60_H.pol,
  parameter int V_POL    = VGA_640x480_60_V.pol,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input logic                vga_clk,
  input logic                reset_n,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = tot(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = tot(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  // One spare count of headroom so the active-end bound is representable for any mode.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  vtg_state_t state_q, state_d;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_tc, v_tc;
  logic          count_en, frame_end, drain_exit;

  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_q, blank_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;
  logic             vb_q, vb_d;
  logic             h_vis, v_vis;

  assign count_en   = vid.pix_ce && (state_q != ST_IDLE);
  assign frame_end  = vid.pix_ce && h_tc && v_tc;
  assign drain_exit = (state_q == ST_DRAIN) && !vid.run && frame_end;

  video_axis_counter #(.TOTAL(H_TOTAL), .W(HW)) u_h_cnt (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .inc_i  (count_en),
    .clr_i  (drain_exit),
    .cnt_o  (h_cnt),
    .tc_o   (h_tc)
  );

  video_axis_counter #(.TOTAL(V_TOTAL), .W(VW)) u_v_cnt (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .inc_i  (count_en && h_tc),
    .clr_i  (drain_exit),
    .cnt_o  (v_cnt),
    .tc_o   (v_tc)
  );

  // run is honoured on any clock; only the drain exit needs a pix_ce at the last pixel.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (vid.run) state_d = ST_RUN;
      ST_RUN:   if (!vid.run) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (vid.run) begin
          state_d = ST_RUN;
        end else if (drain_exit) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign h_vis = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  assign v_vis = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);

  // Outputs hold between pix_ce cycles; strobes are forced low on every non-advancing clock.
  always_comb begin
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    col_d   = col_q;
    row_d   = row_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    vb_d    = 1'b0;
    if (drain_exit) begin
      hs_d    = ~HS_ON;
      vs_d    = ~VS_ON;
      blank_d = 1'b0;
      col_d   = '0;
      row_d   = '0;
    end else if (count_en) begin
      hs_d    = (h_cnt < H_SYNC_END) ? HS_ON : ~HS_ON;
      vs_d    = (v_cnt < V_SYNC_END) ? VS_ON : ~VS_ON;
      blank_d = h_vis && v_vis;
      col_d   = h_vis ? COL_W'(h_cnt - H_ACT_BEG) : '0;
      row_d   = v_vis ? ROW_W'(v_cnt - V_ACT_BEG) : '0;
      ls_d    = (h_cnt == '0);
      fs_d    = (h_cnt == '0) && (v_cnt == '0);
      vb_d    = (h_cnt == '0) && (v_cnt == V_ACT_END);
    end
  end

  always_ff @(negedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      blank_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      vb_q    <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      vb_q    <= vb_d;
    end
  end

  assign vid.running      = (state_q != ST_IDLE);
  assign vid.HS           = hs_q;
  assign vid.VS           = vs_q;
  assign vid.blank_n      = blank_q;
  assign vid.col          = col_q;
  assign vid.row          = row_q;
  assign vid.line_start   = ls_q;
  assign vid.frame_start  = fs_q;
  assign vid.vblank_start = vb_q;
  assign vid.state        = state_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a default 640x480 instance and a small positive-polarity mode instance.
module tb_video_timing_gen;

  localparam int B_HT    = 17;
  localparam int B_VT    = 12;
  localparam int B_FRAME = B_HT * B_VT;
  localparam int NEVER   = 1 << 30;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  video_timing_gen_if #(.COL_W(10), .ROW_W(9)) a_if ();
  video_timing_gen_if #(.COL_W(4),  .ROW_W(4)) b_if ();

  video_timing_gen dut_a (
    .vga_clk (clk),
    .reset_n (rst_a),
    .vid     (a_if)
  );

  video_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(3),
    .H_POL(1), .V_POL(1), .COL_W(4), .ROW_W(4)
  ) dut_b (
    .vga_clk (clk),
    .reset_n (rst_b),
    .vid     (b_if)
  );

  int total = 0;
  int bad   = 0;
  int clk_no = 0;

  // Observations of the small instance, gathered per clock.
  int fs_t[$];
  int vb_t[$];
  int cur_per;
  int s_hs, s_hs_line0, s_vs, s_blank, s_ls, s_fs, s_vb, s_wide;
  int run_fall_t, first_col, max_col, max_row;
  logic p_ls, p_fs, p_vb, p_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    clk_no++;
  endtask

  task automatic clear_stats();
    fs_t.delete();
    vb_t.delete();
    s_hs = 0; s_hs_line0 = 0; s_vs = 0; s_blank = 0;
    s_ls = 0; s_fs = 0; s_vb = 0; s_wide = 0;
    run_fall_t = -1; first_col = -1; max_col = 0; max_row = 0;
    p_ls = 1'b0; p_fs = 1'b0; p_vb = 1'b0; p_run = 1'b0;
  endtask

  task automatic sample_b();
    if (b_if.frame_start)  fs_t.push_back(clk_no);
    if (b_if.vblank_start) vb_t.push_back(clk_no);
    if ((b_if.line_start && p_ls) || (b_if.frame_start && p_fs) || (b_if.vblank_start && p_vb))
      s_wide++;
    if (!b_if.running && p_run && run_fall_t < 0) run_fall_t = clk_no;
    if (fs_t.size() == 1) begin
      if (b_if.HS) s_hs++;
      if (b_if.HS && (clk_no - fs_t[0] < cur_per * B_HT)) s_hs_line0++;
      if (b_if.VS) s_vs++;
      if (b_if.line_start)   s_ls++;
      if (b_if.frame_start)  s_fs++;
      if (b_if.vblank_start) s_vb++;
      if (b_if.blank_n) begin
        s_blank++;
        if (first_col < 0) first_col = int'(b_if.col);
        if (int'(b_if.col) > max_col) max_col = int'(b_if.col);
        if (int'(b_if.row) > max_row) max_row = int'(b_if.row);
      end
    end
    p_ls  = b_if.line_start;
    p_fs  = b_if.frame_start;
    p_vb  = b_if.vblank_start;
    p_run = b_if.running;
  endtask

  task automatic measure_b(input int n, input int per, input int t_off, input int t_on);
    cur_per = per;
    for (int i = 0; i < n; i++) begin
      b_if.run    = !(clk_no >= t_off && clk_no < t_on);
      b_if.pix_ce = ((i % per) == 0);
      tick();
      sample_b();
    end
  endtask

  task automatic restart_b();
    rst_b = 1'b0;
    tick();
    clear_stats();
    clk_no = 0;
    rst_b = 1'b1;
  endtask

  initial begin
    int idle_err_a, idle_err_b;
    int e_hs, e_vs, e_blank, e_col, e_row, e_ls, e_fs, e_vb, hs_low0;

    rst_a = 1'b0; rst_b = 1'b0;
    a_if.pix_ce = 1'b1; a_if.run = 1'b0;
    b_if.pix_ce = 1'b1; b_if.run = 1'b0;
    clear_stats();

    // Reset values, then 1000 idle clocks with run low.
    repeat (3) tick();
    check("rst_a_hs", a_if.HS, 1);
    check("rst_a_vs", a_if.VS, 1);
    check("rst_a_blank", a_if.blank_n, 0);
    check("rst_a_running", a_if.running, 0);
    check("rst_b_hs", b_if.HS, 0);
    check("rst_b_vs", b_if.VS, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    idle_err_a = 0; idle_err_b = 0;
    repeat (1000) begin
      tick();
      if (a_if.HS !== 1'b1 || a_if.VS !== 1'b1 || a_if.blank_n !== 1'b0 || a_if.col !== '0 ||
          a_if.row !== '0 || a_if.running !== 1'b0 || a_if.line_start !== 1'b0 ||
          a_if.frame_start !== 1'b0 || a_if.vblank_start !== 1'b0) idle_err_a++;
      if (b_if.HS !== 1'b0 || b_if.VS !== 1'b0 || b_if.blank_n !== 1'b0 || b_if.col !== '0 ||
          b_if.row !== '0 || b_if.running !== 1'b0 || b_if.line_start !== 1'b0 ||
          b_if.frame_start !== 1'b0 || b_if.vblank_start !== 1'b0) idle_err_b++;
    end
    check("idle_hold_a", idle_err_a, 0);
    check("idle_hold_b", idle_err_b, 0);

    // Default 640x480 mode at full rate: first 37 lines against the line/frame layout.
    a_if.run = 1'b1;
    tick();
    check("a_running_after_run", a_if.running, 1);
    check("a_no_early_fs", a_if.frame_start, 0);
    tick();
    e_hs = 0; e_vs = 0; e_blank = 0; e_col = 0; e_row = 0; e_ls = 0; e_fs = 0; e_vb = 0; hs_low0 = 0;
    for (int k = 0; k < 37 * 800; k++) begin
      int h, v;
      logic hact, vact;
      h = k % 800;
      v = k / 800;
      hact = (h >= 144) && (h < 784);
      vact = (v >= 35) && (v < 515);
      if (a_if.HS !== ((h < 96) ? 1'b0 : 1'b1)) e_hs++;
      if (a_if.VS !== ((v < 2) ? 1'b0 : 1'b1)) e_vs++;
      if (a_if.blank_n !== (hact && vact)) e_blank++;
      if (int'(a_if.col) != (hact ? h - 144 : 0)) e_col++;
      if (int'(a_if.row) != (vact ? v - 35 : 0)) e_row++;
      if (a_if.line_start !== (h == 0)) e_ls++;
      if (a_if.frame_start !== (k == 0)) e_fs++;
      if (a_if.vblank_start !== 1'b0) e_vb++;
      if (v == 0 && a_if.HS === 1'b0) hs_low0++;
      if (k == 35 * 800 + 143) check("a_blank_before_first", a_if.blank_n, 0);
      if (k == 35 * 800 + 144) begin
        check("a_first_blank", a_if.blank_n, 1);
        check("a_first_col", a_if.col, 0);
      end
      if (k == 35 * 800 + 783) check("a_last_col", a_if.col, 639);
      if (k == 36 * 800 + 200) check("a_row1", a_if.row, 1);
      tick();
    end
    check("a_hs_low_line0", hs_low0, 96);
    check("a_hs_pattern", e_hs, 0);
    check("a_vs_pattern", e_vs, 0);
    check("a_blank_pattern", e_blank, 0);
    check("a_col_pattern", e_col, 0);
    check("a_row_pattern", e_row, 0);
    check("a_line_start", e_ls, 0);
    check("a_frame_start", e_fs, 0);
    check("a_vblank_quiet", e_vb, 0);
    a_if.run = 1'b0;

    // Small mode, pix_ce every 2nd clock, active-high syncs.
    restart_b();
    measure_b(830, 2, NEVER, NEVER);
    check("b3_fs_count", fs_t.size(), 3);
    check("b3_fs_first", (fs_t.size() > 0) ? fs_t[0] : -1, 3);
    check("b3_fs_period", (fs_t.size() > 1) ? fs_t[1] - fs_t[0] : -1, 2 * B_FRAME);
    check("b3_vb_offset", (vb_t.size() > 0 && fs_t.size() > 0) ? vb_t[0] - fs_t[0] : -1, 2 * 9 * B_HT);
    check("b3_hs_line0", s_hs_line0, 8);
    check("b3_hs_frame", s_hs, 96);
    check("b3_vs_frame", s_vs, 68);
    check("b3_blank_frame", s_blank, 80);
    check("b3_ls_frame", s_ls, 12);
    check("b3_fs_frame", s_fs, 1);
    check("b3_vb_frame", s_vb, 1);
    check("b3_strobe_width", s_wide, 0);
    check("b3_first_col", first_col, 0);
    check("b3_max_col", max_col, 7);
    check("b3_max_row", max_row, 4);

    // run dropped at line 5: frame drains to idle with no further frame_start.
    restart_b();
    measure_b(500, 1, 2 + 5 * B_HT, NEVER);
    check("b4_fs_count", fs_t.size(), 1);
    check("b4_vb_time", (vb_t.size() > 0) ? vb_t[0] : -1, 2 + 9 * B_HT);
    check("b4_vb_count", vb_t.size(), 1);
    check("b4_run_fall", run_fall_t, 2 + B_FRAME - 1);
    check("b4_ls_count", s_ls, 12);
    check("b4_idle_running", b_if.running, 0);
    check("b4_idle_hs", b_if.HS, 0);
    check("b4_idle_vs", b_if.VS, 0);
    check("b4_idle_blank", b_if.blank_n, 0);
    check("b4_idle_col_row", {b_if.col, b_if.row}, 0);

    // run dropped at line 5 and restored at line 7: frames continue undisturbed.
    restart_b();
    measure_b(420, 1, 2 + 5 * B_HT, 2 + 7 * B_HT);
    check("b5_no_fall", run_fall_t, -1);
    check("b5_fs_count", fs_t.size(), 3);
    check("b5_fs_period1", (fs_t.size() > 1) ? fs_t[1] - fs_t[0] : -1, B_FRAME);
    check("b5_fs_period2", (fs_t.size() > 2) ? fs_t[2] - fs_t[1] : -1, B_FRAME);

    // Reset pulsed inside hsync (h=2), then a clean restart.
    restart_b();
    measure_b(4, 1, NEVER, NEVER);
    check("b6_hs_active_before", b_if.HS, 1);
    check("b6_vs_active_before", b_if.VS, 1);
    #2 rst_b = 1'b0;
    #1;
    check("b6_hs_async_idle", b_if.HS, 0);
    check("b6_vs_async_idle", b_if.VS, 0);
    check("b6_running_async", b_if.running, 0);
    tick();
    clear_stats();
    clk_no = 0;
    rst_b = 1'b1;
    measure_b(420, 1, NEVER, NEVER);
    check("b6_fs_first", (fs_t.size() > 0) ? fs_t[0] : -1, 2);
    check("b6_fs_period", (fs_t.size() > 1) ? fs_t[1] - fs_t[0] : -1, B_FRAME);
    check("b6_hs_line0", s_hs_line0, 4);
    check("b6_vs_frame", s_vs, 34);
    check("b6_blank_frame", s_blank, 40);
    check("b6_ls_frame", s_ls, 12);
    check("b6_strobe_width", s_wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
